// File: rtl/n64_cfg_regs_if.sv
// System clock/reset bundle shared by the configuration blocks.
interface if_system;
    logic clk;
    logic reset;

    modport sys (input clk, input reset);
endinterface

// File: rtl/n64_cfg_regs.sv
// N64 PI halfword register window: command/status, two 32-bit data registers, VERSION.
// Issues a one-cycle command request to the CPU side and accepts CPU data write-back.
module n64_cfg_regs #(
    parameter logic [31:0] VERSION = 32'h0000_0000
) (
    if_system.sys            sys,
    input  logic             n64_request,
    input  logic             n64_write,
    input  logic [2:0]       n64_address,
    input  logic [15:0]      n64_wdata,
    output logic             n64_ack,
    output logic [15:0]      n64_rdata,
    input  logic             cpu_busy,
    input  logic             cmd_error,
    input  logic [1:0]       cpu_data_write,
    input  logic [31:0]      cpu_wdata,
    output logic [7:0]       cmd,
    output logic             cmd_request,
    output logic [1:0][31:0] data
);

    typedef enum logic [2:0] {
        SCR_HI   = 3'd0,
        SCR_LO   = 3'd1,
        DATA0_HI = 3'd2,
        DATA0_LO = 3'd3,
        DATA1_HI = 3'd4,
        DATA1_LO = 3'd5,
        VER_HI   = 3'd6,
        VER_LO   = 3'd7
    } reg_addr_t;

    reg_addr_t   addr;
    logic        idx;
    logic        pending;
    logic        ebusy;
    logic [15:0] wstage;
    logic [15:0] rsnap;
    logic [15:0] rd_mux;

    assign addr  = reg_addr_t'(n64_address);
    assign idx   = n64_address[2];
    assign ebusy = pending | cpu_busy;

    always_comb begin
        rd_mux = '0;
        case (addr)
            SCR_HI:             rd_mux = {ebusy, cmd_error, 14'd0};
            SCR_LO:             rd_mux = {8'd0, cmd};
            DATA0_HI, DATA1_HI: rd_mux = data[idx][31:16];
            DATA0_LO, DATA1_LO: rd_mux = rsnap;
            VER_HI:             rd_mux = VERSION[31:16];
            VER_LO:             rd_mux = VERSION[15:0];
            default:            rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys.clk) begin
        if (sys.reset) begin
            n64_ack     <= 1'b0;
            n64_rdata   <= '0;
            cmd_request <= 1'b0;
            pending     <= 1'b0;
            cmd         <= '0;
            data        <= '0;
            wstage      <= '0;
            rsnap       <= '0;
        end else begin
            n64_ack     <= n64_request;
            n64_rdata   <= (n64_request && !n64_write) ? rd_mux : '0;
            cmd_request <= 1'b0;
            // pending bridges the gap until the CPU side raises cpu_busy
            if (cpu_busy)
                pending <= 1'b0;

            if (n64_request) begin
                if (n64_write) begin
                    if (!ebusy) begin
                        case (addr)
                            SCR_LO: begin
                                cmd         <= n64_wdata[7:0];
                                cmd_request <= 1'b1;
                                pending     <= 1'b1;
                            end
                            DATA0_HI, DATA1_HI: wstage    <= n64_wdata;
                            DATA0_LO, DATA1_LO: data[idx] <= {wstage, n64_wdata};
                            default: ;
                        endcase
                    end
                end else if (addr == DATA0_HI || addr == DATA1_HI) begin
                    rsnap <= data[idx][15:0];
                end
            end

            // CPU write-back is placed last so it wins over a same-cycle N64 commit
            if (cpu_data_write[0])
                data[0] <= cpu_wdata;
            if (cpu_data_write[1])
                data[1] <= cpu_wdata;
        end
    end

endmodule
